// File: rtl/regfile_wb_queue.sv
// Register-file write-back queue: merges load/ALU results into an in-order FIFO,
// retires one write per cycle and answers decode busy/forward queries.
module regfile_wb_queue #(
   parameter int WORDSIZE = 32,
   parameter int DEPTH    = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ld_valid,
   output logic                         ld_ready,
   input  logic [4:0]                   ld_addr,
   input  logic [WORDSIZE-1:0]          ld_data,
   input  logic                         alu_valid,
   output logic                         alu_ready,
   input  logic [4:0]                   alu_addr,
   input  logic [WORDSIZE-1:0]          alu_data,
   output logic                         we,
   output logic [4:0]                   saddr,
   output logic [WORDSIZE-1:0]          wdata,
   input  logic [4:0]                   chk_addr,
   output logic                         chk_busy,
   output logic [WORDSIZE-1:0]          fwd_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] C_LIM1 = CW'(DEPTH-1);
   localparam logic [CW-1:0] C_LIM2 = CW'(DEPTH-2);

   logic [4:0]          r_mem_addr [DEPTH];
   logic [WORDSIZE-1:0] r_mem_data [DEPTH];
   logic [PW-1:0]       r_wr_ptr;
   logic [PW-1:0]       r_rd_ptr;
   logic [CW-1:0]       r_count;
   logic                r_we;
   logic [4:0]          r_saddr;
   logic [WORDSIZE-1:0] r_wdata;

   logic                w_push_ld;
   logic                w_push_alu;
   logic [1:0]          w_n_push;
   logic                w_pop;
   logic [PW-1:0]       w_alu_ptr;

   // Readiness looks only at registered occupancy; a same-cycle retire does not free a slot.
   assign ld_ready  = (r_count <= C_LIM1);
   assign alu_ready = ld_valid ? (r_count <= C_LIM2) : (r_count <= C_LIM1);

   // Writes to x0 finish the handshake but are dropped here.
   assign w_push_ld  = ld_valid  && ld_ready  && (ld_addr  != 5'd0);
   assign w_push_alu = alu_valid && alu_ready && (alu_addr != 5'd0);
   assign w_n_push   = {1'b0, w_push_ld} + {1'b0, w_push_alu};
   assign w_pop      = (r_count != '0);
   assign w_alu_ptr  = r_wr_ptr + PW'(w_push_ld);

   always_ff @(posedge clk) begin
      if (w_push_ld) begin
         r_mem_addr[r_wr_ptr] <= ld_addr;
         r_mem_data[r_wr_ptr] <= ld_data;
      end
      if (w_push_alu) begin
         r_mem_addr[w_alu_ptr] <= alu_addr;
         r_mem_data[w_alu_ptr] <= alu_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_we     <= 1'b0;
         r_saddr  <= '0;
         r_wdata  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + PW'(w_n_push);
         r_count  <= r_count + CW'(w_n_push) - CW'(w_pop);
         r_we     <= w_pop;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
            r_saddr  <= r_mem_addr[r_rd_ptr];
            r_wdata  <= r_mem_data[r_rd_ptr];
         end
      end
   end

   // Scan oldest to youngest so the youngest match overrides; output register is oldest.
   always_comb begin
      chk_busy = 1'b0;
      fwd_data = '0;
      if (chk_addr != 5'd0) begin
         if (r_we && (r_saddr == chk_addr)) begin
            chk_busy = 1'b1;
            fwd_data = r_wdata;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) && (r_mem_addr[r_rd_ptr + PW'(i)] == chk_addr)) begin
               chk_busy = 1'b1;
               fwd_data = r_mem_data[r_rd_ptr + PW'(i)];
            end
         end
      end
   end

   assign we    = r_we;
   assign saddr = r_saddr;
   assign wdata = r_wdata;
   assign count = r_count;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: reset, latency, dual accept, x0 drop,
// occupancy limits with pointer wrap, and busy/forward queries.
module tb_regfile_wb_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_valid, alu_valid;
   logic        ld_ready, alu_ready;
   logic [4:0]  ld_addr, alu_addr, chk_addr;
   logic [31:0] ld_data, alu_data;
   logic        we, chk_busy;
   logic [4:0]  saddr;
   logic [31:0] wdata, fwd_data;
   logic [2:0]  count;

   int total = 0;
   int bad   = 0;

   regfile_wb_queue #(.WORDSIZE(32), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .we(we), .saddr(saddr), .wdata(wdata),
      .chk_addr(chk_addr), .chk_busy(chk_busy), .fwd_data(fwd_data), .count(count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ld_valid = 0; alu_valid = 0;
      ld_addr = 0; alu_addr = 0; ld_data = 0; alu_data = 0;
   endtask

   task automatic test_reset();
      idle_inputs(); chk_addr = 0; rst = 0;
      #12;
      total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", we); end
      total++; if (saddr !== 5'd0 || wdata !== 32'd0) begin bad++; $display("FAIL reset_out got=%0d/%h exp=0/0", saddr, wdata); end
      total++; if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b%b exp=11", ld_ready, alu_ready); end
      @(negedge clk); rst = 1;
      step();
   endtask

   task automatic test_single();
      alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF;
      step();
      idle_inputs();
      total++; if (count !== 3'd1 || we !== 1'b0) begin bad++; $display("FAIL single_k got cnt=%0d we=%b exp cnt=1 we=0", count, we); end
      step();
      total++; if (we !== 1'b1 || saddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wr got we=%b a=%0d d=%h exp 1/5/deadbeef", we, saddr, wdata); end
      total++; if (count !== 3'd0) begin bad++; $display("FAIL single_cnt got=%0d exp=0", count); end
      step();
      total++; if (we !== 1'b0 || saddr !== 5'd5) begin bad++; $display("FAIL single_end got we=%b a=%0d exp we=0 a=5", we, saddr); end
   endtask

   task automatic test_dual();
      ld_valid = 1; ld_addr = 3; ld_data = 32'h1;
      alu_valid = 1; alu_addr = 4; alu_data = 32'h2;
      #1;
      total++; if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin bad++; $display("FAIL dual_ready got=%b%b exp=11", ld_ready, alu_ready); end
      step();
      idle_inputs();
      total++; if (count !== 3'd2) begin bad++; $display("FAIL dual_cnt got=%0d exp=2", count); end
      step();
      total++; if (we !== 1'b1 || saddr !== 5'd3 || wdata !== 32'h1) begin bad++; $display("FAIL dual_first got we=%b a=%0d d=%h exp 1/3/1", we, saddr, wdata); end
      step();
      total++; if (we !== 1'b1 || saddr !== 5'd4 || wdata !== 32'h2) begin bad++; $display("FAIL dual_second got we=%b a=%0d d=%h exp 1/4/2", we, saddr, wdata); end
      step();
      total++; if (we !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL dual_end got we=%b cnt=%0d exp 0/0", we, count); end
   endtask

   task automatic test_zero_addr();
      chk_addr = 0;
      alu_valid = 1; alu_addr = 0; alu_data = 32'hFFFFFFFF;
      #1;
      total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got=%b exp=1", alu_ready); end
      step();
      idle_inputs();
      total++; if (count !== 3'd0 || chk_busy !== 1'b0) begin bad++; $display("FAIL zero_cnt got cnt=%0d busy=%b exp 0/0", count, chk_busy); end
      for (int i = 0; i < 2; i++) begin
         step();
         total++; if (we !== 1'b0) begin bad++; $display("FAIL zero_we cyc=%0d got=%b exp=0", i, we); end
      end
   endtask

   task automatic test_occupancy();
      logic [4:0]  exp_a [6];
      logic [31:0] exp_d [6];
      for (int i = 0; i < 6; i++) begin exp_a[i] = 5'(10 + i); exp_d[i] = 32'h100 + i; end
      ld_valid = 1; ld_addr = exp_a[0]; ld_data = exp_d[0];
      alu_valid = 1; alu_addr = exp_a[1]; alu_data = exp_d[1];
      step();
      total++; if (count !== 3'd2 || we !== 1'b0) begin bad++; $display("FAIL occ_e1 got cnt=%0d we=%b exp 2/0", count, we); end
      ld_addr = exp_a[2]; ld_data = exp_d[2]; alu_addr = exp_a[3]; alu_data = exp_d[3];
      #1;
      total++; if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin bad++; $display("FAIL occ_ready2 got=%b%b exp=11", ld_ready, alu_ready); end
      step();
      total++; if (count !== 3'd3 || we !== 1'b1 || saddr !== exp_a[0]) begin bad++; $display("FAIL occ_e2 got cnt=%0d we=%b a=%0d exp 3/1/10", count, we, saddr); end
      ld_addr = exp_a[4]; ld_data = exp_d[4]; alu_addr = exp_a[5]; alu_data = exp_d[5];
      #1;
      total++; if (ld_ready !== 1'b1 || alu_ready !== 1'b0) begin bad++; $display("FAIL occ_ready3_ld got=%b%b exp=10", ld_ready, alu_ready); end
      step();
      total++; if (count !== 3'd3 || saddr !== exp_a[1] || wdata !== exp_d[1]) begin bad++; $display("FAIL occ_e3 got cnt=%0d a=%0d d=%h exp 3/11/101", count, saddr, wdata); end
      ld_valid = 0;
      #1;
      total++; if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin bad++; $display("FAIL occ_ready3_alu got=%b%b exp=11", ld_ready, alu_ready); end
      step();
      alu_valid = 0;
      total++; if (count !== 3'd3 || saddr !== exp_a[2] || wdata !== exp_d[2]) begin bad++; $display("FAIL occ_e4 got cnt=%0d a=%0d d=%h exp 3/12/102", count, saddr, wdata); end
      for (int i = 3; i < 6; i++) begin
         step();
         total++; if (we !== 1'b1 || saddr !== exp_a[i] || wdata !== exp_d[i] || count !== 3'(5 - i)) begin
            bad++; $display("FAIL occ_drain%0d got we=%b a=%0d d=%h cnt=%0d exp 1/%0d/%h/%0d", i, we, saddr, wdata, count, exp_a[i], exp_d[i], 5 - i);
         end
      end
      step();
      idle_inputs();
      total++; if (we !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL occ_end got we=%b cnt=%0d exp 0/0", we, count); end
   endtask

   task automatic test_forward();
      chk_addr = 7;
      alu_valid = 1; alu_addr = 7; alu_data = 32'hA;
      #1;
      total++; if (chk_busy !== 1'b0) begin bad++; $display("FAIL fwd_sameinput got=%b exp=0", chk_busy); end
      step();
      alu_data = 32'hB;
      total++; if (chk_busy !== 1'b1 || fwd_data !== 32'hA) begin bad++; $display("FAIL fwd_one got busy=%b d=%h exp 1/a", chk_busy, fwd_data); end
      step();
      idle_inputs();
      total++; if (chk_busy !== 1'b1 || fwd_data !== 32'hB) begin bad++; $display("FAIL fwd_young got busy=%b d=%h exp 1/b", chk_busy, fwd_data); end
      chk_addr = 8;
      #1;
      total++; if (chk_busy !== 1'b0 || fwd_data !== 32'h0) begin bad++; $display("FAIL fwd_miss got busy=%b d=%h exp 0/0", chk_busy, fwd_data); end
      chk_addr = 7;
      step();
      total++; if (we !== 1'b1 || wdata !== 32'hB || chk_busy !== 1'b1 || fwd_data !== 32'hB) begin bad++; $display("FAIL fwd_retire got we=%b busy=%b d=%h exp 1/1/b", we, chk_busy, fwd_data); end
      step();
      total++; if (chk_busy !== 1'b0 || fwd_data !== 32'h0) begin bad++; $display("FAIL fwd_clear got busy=%b d=%h exp 0/0", chk_busy, fwd_data); end
      chk_addr = 9;
      ld_valid = 1; ld_addr = 9; ld_data = 32'h11;
      alu_valid = 1; alu_addr = 9; alu_data = 32'h22;
      step();
      idle_inputs();
      total++; if (chk_busy !== 1'b1 || fwd_data !== 32'h22) begin bad++; $display("FAIL fwd_pair got busy=%b d=%h exp 1/22", chk_busy, fwd_data); end
      step();
      step();
      step();
      chk_addr = 0;
   endtask

   task automatic test_async_reset();
      ld_valid = 1; ld_addr = 20; ld_data = 32'h20;
      alu_valid = 1; alu_addr = 21; alu_data = 32'h21;
      step();
      ld_addr = 22; alu_addr = 23;
      step();
      idle_inputs();
      total++; if (count !== 3'd3 || we !== 1'b1) begin bad++; $display("FAIL arst_pre got cnt=%0d we=%b exp 3/1", count, we); end
      #2 rst = 0;
      #1;
      total++; if (we !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL arst_now got we=%b cnt=%0d exp 0/0", we, count); end
      total++; if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b%b exp=11", ld_ready, alu_ready); end
      step();
      @(negedge clk); rst = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         total++; if (we !== 1'b0) begin bad++; $display("FAIL arst_after cyc=%0d got we=%b exp=0", i, we); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_dual();
      test_zero_addr();
      test_occupancy();
      test_forward();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
